// File: rtl/aidan_mcnay_spi_deserializer.sv
// SPI deserializer: synchronizes SCLK/SDI/CS into the clk domain, assembles one
// nbits-wide word per chip-select frame and offers it on a val/rdy stream.
// Frames with the wrong number of SCLK rises, and frames that start while a
// word is still waiting to be taken, are rejected with a one-cycle frame_err.
module aidan_mcnay_spi_deserializer #(
    parameter int nbits       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             SCLK,
    input  logic             SDI,
    input  logic             CS,
    output logic [nbits-1:0] data_out,
    output logic             ostream_val,
    input  logic             ostream_rdy,
    output logic             frame_err
);

    localparam int CNT_W = $clog2(nbits + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(nbits);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sclk_sync, sdi_sync, cs_sync;
    logic                   sclk_prev, sdi_prev, cs_prev;
    logic [SYNC_STAGES:0]   warm;
    logic                   armed;
    logic                   sclk_s, sdi_s, cs_s;
    logic                   sclk_rise, cs_fall, cs_rise;

    logic [nbits-1:0]       shreg;
    logic [CNT_W-1:0]       count;
    logic                   ovf;
    logic                   drop;
    logic                   frame_ok;
    logic                   err_set;
    logic                   drop_set;

    assign sclk_s   = sclk_sync[SYNC_STAGES-1];
    assign sdi_s    = sdi_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign armed    = warm[SYNC_STAGES];
    assign frame_ok = (count == FULL) && !ovf;

    // Pin synchronizer chains; CS idles high so no frame appears out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_sync <= '0;
            sdi_sync  <= '0;
            cs_sync   <= '1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], SDI};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
        end
    end

    // Previous-value flops and registered edge strobes. The warm-up shifter
    // hides the artificial edges produced while the chains refill with the
    // real pin levels after reset, so a CS already low at release is ignored
    // until it goes high and low again. sdi_prev is captured on the same edge
    // as the sclk_rise strobe, keeping the data bit aligned with its clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_prev <= 1'b0;
            sdi_prev  <= 1'b0;
            cs_prev   <= 1'b1;
            warm      <= '0;
            sclk_rise <= 1'b0;
            cs_fall   <= 1'b0;
            cs_rise   <= 1'b0;
        end else begin
            sclk_prev <= sclk_s;
            sdi_prev  <= sdi_s;
            cs_prev   <= cs_s;
            warm      <= {warm[SYNC_STAGES-1:0], 1'b1};
            sclk_rise <= armed &&  sclk_s && !sclk_prev;
            cs_fall   <= armed && !cs_s   &&  cs_prev;
            cs_rise   <= armed &&  cs_s   && !cs_prev;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cs_fall) state_next = SHIFT;
            SHIFT:   if (cs_rise) state_next = frame_ok ? HOLD : IDLE;
            HOLD:    if (ostream_rdy) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: valid while holding, and the error/drop decisions.
    always_comb begin
        ostream_val = (state == HOLD);
        err_set     = cs_rise && (drop || ((state == SHIFT) && !frame_ok));
        drop_set    = (state == HOLD) && cs_fall;
    end

    // Frame datapath: shift register, saturating bit count, overflow and drop
    // flags, output word and error pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg     <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            drop      <= 1'b0;
            data_out  <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= err_set;

            if (drop_set) begin
                drop <= 1'b1;
            end else if (cs_rise) begin
                drop <= 1'b0;
            end

            if ((state == IDLE) && cs_fall) begin
                shreg <= '0;
                count <= '0;
                ovf   <= 1'b0;
            end else if ((state == SHIFT) && sclk_rise && !cs_rise) begin
                shreg <= {shreg[nbits-2:0], sdi_prev};
                if (count == FULL) begin
                    ovf <= 1'b1;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end

            if ((state == SHIFT) && cs_rise && frame_ok) begin
                data_out <= shreg;
            end
        end
    end

endmodule
